// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output collector.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      COLLECT,
      DRAIN
   } collector_state_t;

   localparam int KERNEL_SIZE = 3;

   // Two full line buffers plus the window register and output pipeline stages.
   function automatic int conv_latency(input int row_size);
      return (KERNEL_SIZE - 1) * row_size + KERNEL_SIZE + 2;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head entry; push to head visible 1 cycle later.
// Push is refused when full unless a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic                       head_valid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] store_cnt;
   logic             do_pop;
   logic             do_push;
   logic             load_head;
   logic             from_store;
   logic             bypass;
   logic             to_store;

   assign do_pop     = pop && head_valid;
   assign do_push    = push && (!full || do_pop);
   assign load_head  = !head_valid || do_pop;
   assign from_store = load_head && (store_cnt != '0);
   // An empty store lets a push land straight in the head register.
   assign bypass     = load_head && (store_cnt == '0) && do_push;
   assign to_store   = do_push && !bypass;

   assign count = store_cnt + CNT_W'(head_valid);
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = !head_valid;

   always_ff @(posedge clk) begin
      if (to_store) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         store_cnt  <= '0;
         head_data  <= '0;
         head_valid <= 1'b0;
      end else begin
         if (to_store) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (from_store) begin
            head_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PTR_W'(1);
         end else if (bypass) begin
            head_data <= push_data;
         end
         if (load_head) begin
            head_valid <= from_store || bypass;
         end
         store_cnt <= store_cnt + CNT_W'(to_store) - CNT_W'(from_store);
      end
   end

endmodule

// File: rtl/conv_output_collector.sv
// Keeps only interior 3x3 windows from the convolution stream and queues them with coordinates.
// Push-to-outValid latency 1 cycle; samples arriving while the FIFO is full are dropped (sticky overflow).
module conv_output_collector
   import conv_pkg::*;
#(
   parameter int WORD_SIZE    = 8,
   parameter int ROW_SIZE     = 540,
   parameter int COL_SIZE     = 540,
   parameter int PIPE_LATENCY = conv_latency(ROW_SIZE),
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [WORD_SIZE-1:0]          inputPixel,
   output logic                          outValid,
   input  logic                          outReady,
   output logic [WORD_SIZE-1:0]          outPixel,
   output logic [$clog2(COL_SIZE-2)-1:0] outRow,
   output logic [$clog2(ROW_SIZE-2)-1:0] outCol,
   output logic                          outLast,
   output logic                          busy,
   output logic                          overflow
);

   localparam int ROW_W   = $clog2(COL_SIZE - 2);
   localparam int COL_W   = $clog2(ROW_SIZE - 2);
   localparam int SCAN_W  = $clog2(ROW_SIZE);
   localparam int WARM_W  = $clog2(PIPE_LATENCY) + 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = WORD_SIZE + ROW_W + COL_W + 1;
   localparam int BORDER  = KERNEL_SIZE - 1;

   localparam logic [WARM_W-1:0] WARM_LOAD    = WARM_W'(PIPE_LATENCY - 1);
   localparam logic [SCAN_W-1:0] COL_KEEP_MAX = SCAN_W'(ROW_SIZE - 1 - BORDER);
   localparam logic [SCAN_W-1:0] COL_WRAP     = SCAN_W'(ROW_SIZE - 1);
   localparam logic [ROW_W-1:0]  ROW_FINAL    = ROW_W'(COL_SIZE - 1 - BORDER);

   collector_state_t   state;
   collector_state_t   next_state;
   logic [WARM_W-1:0]  warm_cnt;
   logic [SCAN_W-1:0]  scan_col;
   logic [ROW_W-1:0]   scan_row;
   logic               keep;
   logic               final_pos;
   logic               pop;
   logic               drop;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_data;
   logic               head_valid;
   logic [CNT_W-1:0]   fifo_cnt;
   logic               fifo_full;
   logic               fifo_empty;

   assign pop        = head_valid && outReady;
   // Columns past COL_KEEP_MAX are windows straddling two input rows.
   assign keep       = (state == COLLECT) && (scan_col <= COL_KEEP_MAX);
   assign final_pos  = (scan_row == ROW_FINAL) && (scan_col == COL_KEEP_MAX);
   assign drop       = keep && fifo_full && !pop;
   assign push_entry = {inputPixel, scan_row, scan_col[COL_W-1:0], final_pos};

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = WARMUP;
         // Leave on the edge the counter reaches zero so raw (0,0) is the first COLLECT sample.
         WARMUP:  if (warm_cnt <= WARM_W'(1)) next_state = COLLECT;
         COLLECT: if (final_pos) next_state = DRAIN;
         DRAIN:   if (fifo_empty || (fifo_cnt == CNT_W'(1) && pop)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         warm_cnt <= '0;
         scan_col <= '0;
         scan_row <= '0;
         overflow <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               warm_cnt <= WARM_LOAD;
               scan_col <= '0;
               scan_row <= '0;
               if (start) overflow <= 1'b0;
            end
            WARMUP: begin
               if (warm_cnt != '0) warm_cnt <= warm_cnt - WARM_W'(1);
            end
            COLLECT: begin
               if (scan_col == COL_WRAP) begin
                  scan_col <= '0;
                  scan_row <= scan_row + ROW_W'(1);
               end else begin
                  scan_col <= scan_col + SCAN_W'(1);
               end
               if (drop) overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (keep),
      .push_data  (push_entry),
      .pop        (outReady),
      .head_data  (head_data),
      .head_valid (head_valid),
      .count      (fifo_cnt),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign outValid = head_valid;
   assign {outPixel, outRow, outCol, outLast} = head_data;
   assign busy = (state != IDLE);

endmodule

// File: doc/conv_output_collector.md
# conv_output_collector

Consumer for the 3x3 convolution's unhandshaked output stream. Sits directly after `convolution` and aligns to its fill and pipeline latency. Discards warm-up cycles and row-wrap border windows. Buffers only the valid pixels and presents them, tagged with output coordinates, over a valid/ready interface to downstream storage or the next CNN layer.

## Interface
- `WORD_SIZE`, 8, pixel width.
- `ROW_SIZE`, 540, input pixels per row.
- `COL_SIZE`, 540, input rows per frame.
- `PIPE_LATENCY`, 2*ROW_SIZE+5, cycles from the first input pixel entering `convolution` to raw window (0,0) appearing on its output.
- `FIFO_DEPTH`, 16, output buffer entries; must be a power of two.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse on the cycle the frame's first pixel is driven into `convolution`.
- `inputPixel` in WORD_SIZE: `convolution` outputPixel, sampled every cycle.
- `outValid` out 1: FIFO head valid.
- `outReady` in 1: downstream accept.
- `outPixel` out WORD_SIZE: head pixel.
- `outRow` out $clog2(COL_SIZE-2): output row, 0..COL_SIZE-3.
- `outCol` out $clog2(ROW_SIZE-2): output column, 0..ROW_SIZE-3.
- `outLast` out 1: head is the frame's final pixel.
- `busy` out 1: state != IDLE.
- `overflow` out 1: sticky; a kept pixel was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, WARMUP, COLLECT, DRAIN.
- IDLE:
  - `start`=1 goes to WARMUP.
  - Loads the warm-up counter with PIPE_LATENCY-1.
  - Clears `overflow`.
- WARMUP: counts down to 0, then goes to COLLECT. All `inputPixel` values are ignored.
- COLLECT raw scan position (r,c):
  - Starts at (0,0) and advances one position per cycle.
  - c wraps at ROW_SIZE-1, incrementing r.
  - r spans 0..COL_SIZE-3.
- COLLECT keep/discard rule:
  - Sample is kept iff c <= ROW_SIZE-3.
  - c = ROW_SIZE-2 and ROW_SIZE-1 are row-straddling windows and are discarded.
  - A kept sample is pushed as {pixel, r, c, last}.
  - last=1 only at r=COL_SIZE-3, c=ROW_SIZE-3.
- COLLECT exit: after pushing the last sample, go to DRAIN. COLLECT lasts (COL_SIZE-2)*ROW_SIZE-2 cycles.
- DRAIN: returns to IDLE on the cycle the FIFO becomes empty. Goes directly to IDLE if it is already empty.
- Push rule:
  - Push succeeds if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set.
  - `overflow` stays set until the next accepted `start`.
- Pop occurs when `outValid && outReady`.
- `start` is ignored outside IDLE.
- Total kept pixels per frame: (ROW_SIZE-2)*(COL_SIZE-2), in raster order.
- Reset (including mid-frame):
  - State goes to IDLE and the FIFO is emptied.
  - All counters are zeroed and all outputs go to 0: `outValid`, `outPixel`, `outRow`, `outCol`, `outLast`, `busy`, `overflow`.

## Timing
- `start` is sampled at edge E0. `inputPixel` sampled at edge E0+PIPE_LATENCY is raw (0,0).
- Push at edge E makes `outValid`=1 and the head fields valid in the cycle after E. Latency: 1 cycle.
- Output fields are registered FIFO outputs. They hold stable while `outValid && !outReady`.
- Simultaneous push and pop with the FIFO full: both succeed and the count is unchanged.
- Simultaneous push and pop with the FIFO empty: the pop is not possible; the push lands.
- `busy` rises the cycle after the `start` edge and falls the cycle after the final pop.

## Structure
- Package `conv_pkg`:
  - `collector_state_t` enum.
  - `KERNEL_SIZE`=3 constant.
  - Function `conv_latency(ROW_SIZE)` returning 2*ROW_SIZE+5, used for the PIPE_LATENCY default.
- Sub-module `sync_fifo`:
  - Parameterized width and depth, first-word-registered.
  - Width is WORD_SIZE + row width + column width + 1.
  - Exposes count/full/empty.
- The FSM, scan counters and keep logic live in the top module.

## Test plan
All scenarios use ROW_SIZE=5, COL_SIZE=4, PIPE_LATENCY=4, FIFO_DEPTH=4 and drive `inputPixel` = 8'h10+k on COLLECT cycle k (0..7).
- Nominal, `outReady`=1:
  - Outputs 10,11,12,15,16,17 at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - `outLast` only with 17; `overflow`=0.
  - `busy` falls after the 6th pop.
- Warm-up alignment: `inputPixel`=FF during WARMUP. No FF is ever emitted, and the first push follows edge E0+4.
- Backpressure, `outReady`=0 through COLLECT:
  - FIFO holds 10,11,12,15; 16 and 17 are dropped and `overflow`=1.
  - Raising `outReady` then yields exactly those 4 pixels, with no `outLast`.
- Toggled `outReady` (1,0,1,0...): all 6 pixels are delivered in order. Held fields do not change while stalled.
- `start` pulsed during WARMUP and again during COLLECT: both are ignored and the frame completes identically to nominal.
- `rst` at COLLECT cycle 3:
  - All outputs are 0 the next cycle and the FIFO is empty.
  - A new `start` then produces the nominal sequence from 10.
